// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming(7,4) transmit link: serializer states,
// codeword/frame geometry and the reference encoder.
package ham_pkg;

  localparam int CW_W       = 7;
  localparam int FRAME_BITS = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Data occupies cw[3:0]; parities sit above it in the link's layout.
  function automatic logic [CW_W-1:0] ham74_encode(input logic [3:0] d);
    ham74_encode = {d[1] ^ d[2] ^ d[3],
                    d[0] ^ d[2] ^ d[3],
                    d[0] ^ d[1] ^ d[3],
                    d};
  endfunction

endpackage

// File: rtl/ham_sync_fifo.sv
// Single-clock FIFO holding encoded codewords; a word pushed into an empty
// FIFO becomes visible on rdata from the following cycle.
module ham_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) transmit stage: encodes nibbles (with optional single-bit
// error injection), buffers codewords and shifts them out as 9-bit frames.
module hamming_tx_serializer
  import ham_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [3:0]             in_data,
  input  logic                   inj_en,
  input  logic [2:0]             inj_pos,
  output logic                   in_ready,
  output logic                   tx_line,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam logic [7:0] BIT_LAST = 8'(DIV - 1);
  localparam logic [2:0] IDX_LAST = 3'(FRAME_BITS - 3);

  logic [CW_W-1:0] cw_enc, flip_mask, cw_push, fifo_rdata;
  logic            fifo_full, fifo_empty, push, pop, bit_end;

  tx_state_e       state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW_W-1:0] sreg_q, sreg_d;
  logic            line_q, line_d;
  logic            busy_q, busy_d;
  logic            rdy_en_q;

  assign cw_enc    = ham74_encode(in_data);
  assign flip_mask = (inj_en && inj_pos != 3'd7) ? (7'(1) << inj_pos) : '0;
  assign cw_push   = cw_enc ^ flip_mask;

  // rdy_en_q keeps in_ready low while reset is held, even though the FIFO is empty.
  assign in_ready  = rdy_en_q && !fifo_full;
  assign push      = in_valid && in_ready;
  assign bit_end   = (cnt_q == BIT_LAST);
  assign pop       = !fifo_empty &&
                     ((state_q == IDLE) || (state_q == STOP && bit_end));

  ham_sync_fifo #(
    .WIDTH (CW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (cw_push),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        line_d = 1'b1;
        if (!fifo_empty) begin
          sreg_d  = fifo_rdata;
          state_d = START;
          line_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          line_d  = sreg_q[0];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
            line_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 3'd1;
            sreg_d = sreg_q >> 1;
            line_d = sreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more work is queued.
          if (!fifo_empty) begin
            sreg_d  = fifo_rdata;
            state_d = START;
            line_d  = 1'b0;
          end else begin
            state_d = IDLE;
            line_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
    // IDLE always pops a non-empty FIFO, so a stale entry implies state_d != IDLE.
    busy_d = (state_d != IDLE) || push || !fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sreg_q   <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sreg_q   <= sreg_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign tx_line = line_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: a line receiver rebuilds codewords from
// tx_line and they are compared against a parity/brute-force decode model.
module tb_hamming_tx_serializer;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int CW_W  = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [3:0]      in_data;
  logic            inj_en;
  logic [2:0]      inj_pos;
  logic            in_ready;
  logic            tx_line;
  logic            tx_busy;
  logic [CW_W-1:0] fifo_count;

  hamming_tx_serializer #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .inj_en     (inj_en),
    .inj_pos    (inj_pos),
    .in_ready   (in_ready),
    .tx_line    (tx_line),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] rx_q [$];
  longint     rx_t [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Codeword from the parity rules: each parity bit covers a fixed subset of data bits.
  function automatic logic [6:0] model_cw(input logic [3:0] d, input bit en, input logic [2:0] pos);
    logic [3:0] masks [3];
    logic [6:0] cw;
    masks[0] = 4'b1011;
    masks[1] = 4'b1101;
    masks[2] = 4'b1110;
    cw[3:0] = d;
    for (int k = 0; k < 3; k++) cw[4+k] = ^(d & masks[k]);
    if (en && pos != 3'd7) cw[pos] = ~cw[pos];
    return cw;
  endfunction

  // Brute-force correction: find the single flip (or none) yielding a valid codeword.
  function automatic logic [3:0] model_decode(input logic [6:0] rx);
    logic [6:0] t;
    for (int p = -1; p < 7; p++) begin
      t = rx;
      if (p >= 0) t[p] = ~t[p];
      if (model_cw(t[3:0], 1'b0, 3'd7) == t) return t[3:0];
    end
    return 4'hx;
  endfunction

  // Line receiver: samples each bit period, checks bit stability and stop bit.
  initial begin : monitor
    logic [8:0] bits;
    bit         abort, stable;
    longint     t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_line === 1'b0) begin
        t0 = cyc; abort = 1'b0; stable = 1'b1; bits = '0;
        for (int i = 0; i < 9*DIV; i++) begin
          if (i > 0) begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin abort = 1'b1; break; end
          end
          if (i % DIV == 0) bits[i/DIV] = tx_line;
          else if (tx_line !== bits[i/DIV]) stable = 1'b0;
        end
        if (!abort) begin
          check("frame_stop_bit", 32'(bits[8]), 32'd1);
          check("frame_bits_stable", 32'(stable), 32'd1);
          rx_q.push_back(bits[7:1]);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic push(input logic [3:0] d, input bit en, input logic [2:0] pos);
    bit acc, done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; inj_en = en; inj_pos = pos;
    for (int t = 0; t < 1000; t++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin done = 1'b1; break; end
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; inj_en = 1'b0; inj_pos = 3'd7;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (tx_busy === 1'b0) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0] d;
    bit         en;
    logic [2:0] pos;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl [10];
  logic [6:0] exp_q [$];
  logic [3:0] sent_q [$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  t_start, t_end;
    bit  acc, saw_full, high;
    logic [3:0] d;
    bit en;
    logic [2:0] pos;

    tbl[0] = '{4'hB, 1'b0, 3'd7, 7'h1B};
    tbl[1] = '{4'h0, 1'b0, 3'd0, 7'h00};
    tbl[2] = '{4'hF, 1'b0, 3'd0, 7'h7F};
    tbl[3] = '{4'hB, 1'b1, 3'd5, 7'h3B};
    tbl[4] = '{4'hB, 1'b1, 3'd7, 7'h1B};
    tbl[5] = '{4'h5, 1'b0, 3'd7, 7'h55};
    tbl[6] = '{4'h6, 1'b0, 3'd7, 7'h36};
    tbl[7] = '{4'h1, 1'b1, 3'd0, 7'h30};
    tbl[8] = '{4'h6, 1'b1, 3'd6, 7'h76};
    tbl[9] = '{4'h9, 1'b1, 3'd3, 7'h41};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_pos = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_line", 32'(tx_line), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", 32'(in_ready), 32'd1);

    // Single frame timing for 4'b1011.
    rx_q.delete(); rx_t.delete();
    push(4'hB, 1'b0, 3'd7);
    check("busy_at_push", 32'(tx_busy), 32'd1);
    check("line_at_push", 32'(tx_line), 32'd1);
    t_start = -1; t_end = -1;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      if (t_start < 0 && tx_line === 1'b0) t_start = k;
      if (tx_busy === 1'b0) begin t_end = k; break; end
    end
    check("start_bit_edge", 32'(t_start), 32'd1);
    check("busy_fall_edge", 32'(t_end), 32'(1 + 9*DIV));
    check("frame_len", 32'(t_end - t_start), 32'(9*DIV));
    check("single_frame_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("single_frame_cw", 32'(rx_q[0]), 32'h1B);

    // Back-to-back frames with no idle gap.
    rx_q.delete(); rx_t.delete();
    push(4'h0, 1'b0, 3'd7);
    push(4'hF, 1'b0, 3'd7);
    wait_idle();
    check("b2b_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check("b2b_cw0", 32'(rx_q[0]), 32'h00);
      check("b2b_cw1", 32'(rx_q[1]), 32'h7F);
      check("b2b_gap", 32'(rx_t[1] - rx_t[0]), 32'(9*DIV));
    end

    // Table of single-nibble vectors.
    foreach (tbl[i]) begin
      rx_q.delete();
      push(tbl[i].d, tbl[i].en, tbl[i].pos);
      wait_idle();
      check($sformatf("tbl%0d_count", i), 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check($sformatf("tbl%0d_cw", i), 32'(rx_q[0]), 32'(tbl[i].exp));
    end

    // Continuous random traffic with backpressure.
    rx_q.delete(); exp_q.delete(); saw_full = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      d = 4'($urandom); en = 1'($urandom); pos = 3'($urandom_range(0, 7));
      in_data = d; inj_en = en; inj_pos = pos;
      acc = in_ready;
      if (fifo_count == CW_W'(DEPTH)) saw_full = 1'b1;
      check("ready_eq_not_full", 32'(in_ready), 32'(fifo_count != CW_W'(DEPTH)));
      if (fifo_count > CW_W'(DEPTH)) check("count_bound", 32'(fifo_count), 32'(DEPTH));
      @(posedge clk); #1;
      if (acc) exp_q.push_back(model_cw(d, en, pos));
    end
    in_valid = 1'b0; inj_en = 1'b0; inj_pos = 3'd7;
    wait_idle();
    check("rand_saw_full", 32'(saw_full), 32'd1);
    check("rand_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("rand_cw%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));

    // Loopback through the correcting decoder: every nibble and error position.
    rx_q.delete(); sent_q.delete();
    for (int n = 0; n < 16; n++)
      for (int p = 0; p < 7; p++) begin
        push(4'(n), 1'b1, 3'(p));
        sent_q.push_back(4'(n));
      end
    wait_idle();
    check("loop_count", 32'(rx_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
      check($sformatf("loop_dec%0d", i), 32'(model_decode(rx_q[i])), 32'(sent_q[i]));

    // Reset asserted in the middle of the data bits of a frame.
    rx_q.delete();
    push(4'h0, 1'b0, 3'd7);
    push(4'h0, 1'b0, 3'd7);
    push(4'h0, 1'b0, 3'd7);
    repeat (16) @(posedge clk);
    #1;
    check("mid_data_line_low", 32'(tx_line), 32'd0);
    check("mid_data_count", 32'(fifo_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_line", 32'(tx_line), 32'd1);
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_busy", 32'(tx_busy), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    high = 1'b1;
    for (int c = 0; c < 20*DIV; c++) begin
      if (tx_line !== 1'b1) high = 1'b0;
      @(posedge clk); #1;
    end
    check("post_rst_line_idle", 32'(high), 32'd1);
    check("post_rst_busy", 32'(tx_busy), 32'd0);
    check("post_rst_no_frame", 32'(rx_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
